fabric_bench_output_checker: RTL and testbench
==============================================

// Module: fabric_bench_output_checker
// PURPOSE
//   Synthesizable, parametrised compare engine for formal-verification tops.
//   Samples NUM_CH fabric (gfpga) outputs against benchmark outputs every cycle
//   after a warm-up window, for a fixed run length.
//   Keeps sticky per-channel flags, a saturating error count and first-mismatch info,
//   then raises done/pass. Sits beside the fabric and reference instances; replaces
//   simulation-only flag/counter logic so the same check runs in emulation.
// PARAMETERS
//   NUM_CH      16  number of compared output channels (>=1)
//   CNT_W       16  width of error and cycle counters
//   WARMUP       1  cycles skipped after start before comparing (>=0)
//   RUN_CYCLES  10  compare cycles per run (>=1, < 2**CNT_W)
// PORTS
//   clk_i            in   1          single clock, all logic on rising edge
//   rstn_i           in   1          asynchronous active-low reset
//   start_i          in   1          pulse: begin run (accepted in IDLE or DONE)
//   gfpga_i          in   NUM_CH     fabric outputs
//   bench_i          in   NUM_CH     benchmark outputs
//   bench_valid_i    in   NUM_CH     1 = bench bit is known (replaces X test); 0 = don't care
//   busy_o           out  1          high in WARMUP or CHECK
//   done_o           out  1          run complete, held until next start or reset
//   pass_o           out  1          done_o && err_cnt_o==0
//   err_flag_o       out  NUM_CH     sticky per-channel mismatch flags
//   err_cnt_o        out  CNT_W      saturating mismatch count
//   first_vld_o      out  1          first-mismatch fields valid
//   first_ch_o       out  $clog2(NUM_CH) (min 1)  lowest channel index of first mismatch
//   first_cyc_o      out  CNT_W      compare-cycle index (0-based) of first mismatch
// BEHAVIOUR
//   Reset: state IDLE; every output 0; all counters 0.
//   mis[i] = bench_valid_i[i] & (gfpga_i[i] ^ bench_i[i]).
//   FSM: IDLE -start-> WARMUP (WARMUP==0: straight to CHECK) -WARMUP cycles-> CHECK
//        -RUN_CYCLES compare edges-> DONE -start-> WARMUP/CHECK.
//   start_i: clears flags, counters, first_* and done/pass on the same edge it is accepted;
//     ignored while busy_o=1.
//   CHECK: each edge samples mis; err_flag_o |= mis, visible next cycle (1-cycle latency).
//   err_cnt_o += popcount(mis) per compare cycle; saturates at 2**CNT_W-1, never wraps.
//   first_*: loaded on the first compare cycle with |mis; lowest index wins on ties;
//     first_vld_o then stays 1 until start/reset.
//   done_o rises the cycle after the last compare edge; inputs in DONE/IDLE are not compared.
//   Reset asserted mid-run: immediate return to IDLE, everything cleared, no done.
// CONFIGURATION
//   CHECKER_EDGE_COUNT_EN defined: err_cnt_o counts only rising mismatch per channel
//     (mis[i] & ~mis_q[i], mis_q cleared at start), matching legacy posedge-flag counting.
//   Undefined (default): every mismatching channel-cycle is counted.
// TESTING  (NUM_CH=4, CNT_W=4, WARMUP=1, RUN_CYCLES=10 unless noted)
//   1 gfpga_i==bench_i all run, valid=4'hF -> done_o 12 cycles after start, pass_o=1, err_cnt_o=0.
//   2 ch2 flips on compare cycles 3,4,5 -> err_flag_o=4'b0100, err_cnt_o=3 (1 with
//     CHECKER_EDGE_COUNT_EN), first_ch_o=2, first_cyc_o=3, pass_o=0.
//   3 ch1 and ch3 mismatch together at cycle 0 -> first_ch_o=1, err_cnt_o=2.
//   4 all 4 channels mismatch every cycle, CNT_W=4 -> err_cnt_o saturates at 15, no wrap;
//     bench_valid_i=0 on same data -> err_cnt_o=0, pass_o=1.
//   5 rstn_i low at compare cycle 5 -> all outputs 0, state IDLE; start_i while busy -> ignored.

Source files
------------

// File: rtl/fabric_bench_output_checker.sv
// fabric_bench_output_checker: per-cycle compare engine between fabric (gfpga)
// outputs and benchmark outputs. After start it skips WARMUP cycles, then
// compares for RUN_CYCLES edges. It keeps sticky per-channel flags, a
// saturating error count and the first-mismatch location, then reports done/pass.
// Optional macro CHECKER_EDGE_COUNT_EN: count only rising mismatches per channel.
module fabric_bench_output_checker #(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WARMUP     = 1,
  parameter int unsigned RUN_CYCLES = 10,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] gfpga_i,
  input  logic [NUM_CH-1:0] bench_i,
  input  logic [NUM_CH-1:0] bench_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [NUM_CH-1:0] err_flag_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              first_vld_o,
  output logic [CH_W-1:0]   first_ch_o,
  output logic [CNT_W-1:0]  first_cyc_o
);

  localparam int unsigned PC_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [NUM_CH-1:0]  err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               first_vld_q, first_vld_d;
  logic [CH_W-1:0]    first_ch_q, first_ch_d;
  logic [CNT_W-1:0]   first_cyc_q, first_cyc_d;
`ifdef CHECKER_EDGE_COUNT_EN
  logic [NUM_CH-1:0]  mis_q, mis_d;
`endif

  logic [NUM_CH-1:0]  mis_c;
  logic [NUM_CH-1:0]  cnt_mask_c;
  logic [PC_W-1:0]    pc_c;
  logic [CNT_W:0]     sum_c;
  logic [CNT_W-1:0]   cnt_sat_c;
  logic [CH_W-1:0]    low_idx_c;

  // Mismatch vector, per-cycle increment, saturated count and lowest mismatching channel
  always_comb begin
    mis_c = bench_valid_i & (gfpga_i ^ bench_i);
`ifdef CHECKER_EDGE_COUNT_EN
    cnt_mask_c = mis_c & ~mis_q;
`else
    cnt_mask_c = mis_c;
`endif
    pc_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pc_c = pc_c + PC_W'(cnt_mask_c[i]);
    end
    sum_c     = {1'b0, err_cnt_q} + (CNT_W + 1)'(pc_c);
    cnt_sat_c = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
    low_idx_c = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mis_c[i]) low_idx_c = CH_W'(i);
    end
  end

  // Next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    first_vld_d = first_vld_q;
    first_ch_d  = first_ch_q;
    first_cyc_d = first_cyc_q;
`ifdef CHECKER_EDGE_COUNT_EN
    mis_d       = mis_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
          cyc_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_flag_d  = '0;
          err_cnt_d   = '0;
          first_vld_d = 1'b0;
          first_ch_d  = '0;
          first_cyc_d = '0;
`ifdef CHECKER_EDGE_COUNT_EN
          mis_d       = '0;
`endif
        end
      end
      ST_WARMUP: begin
        if (cyc_q == WARM_LAST) begin
          state_d = ST_CHECK;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        err_flag_d = err_flag_q | mis_c;
        err_cnt_d  = cnt_sat_c;
`ifdef CHECKER_EDGE_COUNT_EN
        mis_d      = mis_c;
`endif
        if (!first_vld_q && (|mis_c)) begin
          first_vld_d = 1'b1;
          first_ch_d  = low_idx_c;
          first_cyc_d = cyc_q;
        end
        if (cyc_q == RUN_LAST) begin
          state_d = ST_DONE;
          cyc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_sat_c == '0);
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_flag_q  <= '0;
      err_cnt_q   <= '0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      first_cyc_q <= '0;
`ifdef CHECKER_EDGE_COUNT_EN
      mis_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      first_cyc_q <= first_cyc_d;
`ifdef CHECKER_EDGE_COUNT_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_flag_o  = err_flag_q;
  assign err_cnt_o   = err_cnt_q;
  assign first_vld_o = first_vld_q;
  assign first_ch_o  = first_ch_q;
  assign first_cyc_o = first_cyc_q;

endmodule

// File: tb/tb_fabric_bench_output_checker.sv
// Bench for fabric_bench_output_checker (NUM_CH=4, CNT_W=4, WARMUP=1, RUN_CYCLES=10).
// Honours CHECKER_EDGE_COUNT_EN the same way the design does.
module tb_fabric_bench_output_checker;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WARMUP     = 1;
  localparam int unsigned RUN_CYCLES = 10;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [NUM_CH-1:0] gfpga, bench, bvalid;
  logic              busy, done, pass, first_vld;
  logic [NUM_CH-1:0] err_flag;
  logic [CNT_W-1:0]  err_cnt, first_cyc;
  logic [1:0]        first_ch;

  int n_vec = 0;
  int n_err = 0;

  logic [NUM_CH-1:0] g_a [RUN_CYCLES];
  logic [NUM_CH-1:0] b_a [RUN_CYCLES];
  logic [NUM_CH-1:0] v_a [RUN_CYCLES];

  fabric_bench_output_checker #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WARMUP(WARMUP), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .gfpga_i(gfpga), .bench_i(bench), .bench_valid_i(bvalid),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_flag_o(err_flag), .err_cnt_o(err_cnt),
    .first_vld_o(first_vld), .first_ch_o(first_ch), .first_cyc_o(first_cyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs that always mismatch; used in cycles that must not be compared
  task automatic drive_junk();
    gfpga  = NUM_CH'($urandom);
    bench  = ~gfpga;
    bvalid = '1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".flag"}, 32'(err_flag), 0);
    chk({tag, ".cnt"}, 32'(err_cnt), 0);
    chk({tag, ".fvld"}, 32'(first_vld), 0);
    chk({tag, ".fch"}, 32'(first_ch), 0);
    chk({tag, ".fcyc"}, 32'(first_cyc), 0);
  endtask

  // One full run over g_a/b_a/v_a; optional extra start pulse at compare index pulse_k
  task automatic run(input string tag, input int pulse_k);
    logic [NUM_CH-1:0] mis, cm, prev, exp_flag;
    int exp_cnt, exp_fch, exp_fcyc;
    bit exp_fvld;
    prev = '0; exp_flag = '0; exp_cnt = 0; exp_fvld = 0; exp_fch = 0; exp_fcyc = 0;
    @(negedge clk);
    start = 1'b1;
    drive_junk();
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".st.busy"}, 32'(busy), 1);
    chk({tag, ".st.done"}, 32'(done), 0);
    chk({tag, ".st.cnt"}, 32'(err_cnt), 0);
    chk({tag, ".st.flag"}, 32'(err_flag), 0);
    chk({tag, ".st.fvld"}, 32'(first_vld), 0);
    drive_junk();
    @(negedge clk);
    chk({tag, ".wu.flag"}, 32'(err_flag), 0);
    for (int k = 0; k < int'(RUN_CYCLES); k++) begin
      gfpga  = g_a[k];
      bench  = b_a[k];
      bvalid = v_a[k];
      start  = (k == pulse_k);
      mis = v_a[k] & (g_a[k] ^ b_a[k]);
`ifdef CHECKER_EDGE_COUNT_EN
      cm = mis & ~prev;
`else
      cm = mis;
`endif
      prev = mis;
      exp_flag = exp_flag | mis;
      exp_cnt  = exp_cnt + $countones(cm);
      if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
      if (!exp_fvld && mis != 0) begin
        exp_fvld = 1;
        exp_fcyc = k;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) if (mis[c]) exp_fch = c;
      end
      @(negedge clk);
      chk($sformatf("%s.k%0d.flag", tag, k), 32'(err_flag), 32'(exp_flag));
      chk($sformatf("%s.k%0d.cnt", tag, k), 32'(err_cnt), 32'(exp_cnt));
      chk($sformatf("%s.k%0d.busy", tag, k), 32'(busy), 32'(k != int'(RUN_CYCLES) - 1));
      chk($sformatf("%s.k%0d.done", tag, k), 32'(done), 32'(k == int'(RUN_CYCLES) - 1));
    end
    start = 1'b0;
    chk({tag, ".pass"}, 32'(pass), 32'(exp_cnt == 0));
    chk({tag, ".fvld"}, 32'(first_vld), 32'(exp_fvld));
    chk({tag, ".fch"}, 32'(first_ch), 32'(exp_fch));
    chk({tag, ".fcyc"}, 32'(first_cyc), 32'(exp_fcyc));
    drive_junk();
    @(negedge clk);
    chk({tag, ".hold.done"}, 32'(done), 1);
    chk({tag, ".hold.cnt"}, 32'(err_cnt), 32'(exp_cnt));
    chk({tag, ".hold.flag"}, 32'(err_flag), 32'(exp_flag));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0;
    gfpga = '0; bench = '0; bvalid = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1: identical data, all valid
    for (int k = 0; k < int'(RUN_CYCLES); k++) begin
      g_a[k] = NUM_CH'($urandom); b_a[k] = g_a[k]; v_a[k] = '1;
    end
    run("match", -1);

    // 2: channel 2 flips on compare cycles 3..5
    for (int k = 0; k < int'(RUN_CYCLES); k++) begin
      g_a[k] = NUM_CH'($urandom); v_a[k] = '1;
      b_a[k] = (k >= 3 && k <= 5) ? (g_a[k] ^ 4'b0100) : g_a[k];
    end
    run("ch2", -1);

    // 3: channels 1 and 3 mismatch together at cycle 0
    for (int k = 0; k < int'(RUN_CYCLES); k++) begin
      g_a[k] = NUM_CH'($urandom); v_a[k] = '1;
      b_a[k] = (k == 0) ? (g_a[k] ^ 4'b1010) : g_a[k];
    end
    run("tie", -1);

    // 4: every channel mismatches every cycle -> saturation; then masked by valid=0
    for (int k = 0; k < int'(RUN_CYCLES); k++) begin
      g_a[k] = NUM_CH'($urandom); b_a[k] = ~g_a[k]; v_a[k] = '1;
    end
    run("sat", -1);
    for (int k = 0; k < int'(RUN_CYCLES); k++) v_a[k] = '0;
    run("novld", -1);

    // Random runs, one with a start pulse mid-run that must be ignored
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < int'(RUN_CYCLES); k++) begin
        g_a[k] = NUM_CH'($urandom);
        b_a[k] = NUM_CH'($urandom);
        v_a[k] = NUM_CH'($urandom);
      end
      run($sformatf("rnd%0d", r), (r == 1) ? 4 : -1);
    end

    // 5: reset asserted at compare cycle 5
    @(negedge clk);
    start = 1'b1;
    drive_junk();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_junk();
      @(negedge clk);
    end
    chk("midrst.pre.flag", 32'(err_flag != 0), 1);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      drive_junk();
      @(negedge clk);
    end
    chk_all_zero("idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
